// File: rtl/march_seq_ctrl.sv
// March C- SRAM BIST sequencer with first-failure capture.
// Define MARCH_STOP_ON_FAIL_EN to end a test at its first miscompare.
module march_seq_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] BG = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mem_cs,
  output logic              mem_rwbar,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t              r_state;
  state_t              w_nxt_state;
  logic [2:0]          r_elem;
  logic [2:0]          w_nxt_elem;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_nxt_addr;

  logic [7:0]          r_fail_count;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [DATA_W-1:0]   r_fail_exp;
  logic [DATA_W-1:0]   r_fail_act;
  logic                r_pass;

  logic                w_down;
  logic                w_nxt_down;
  logic                w_last;
  logic                w_launch;
  logic                w_kill;
  logic                w_miss;
  logic [ADDR_W-1:0]   w_step;
  logic [DATA_W-1:0]   w_wval;
  logic [DATA_W-1:0]   w_rexp;

  // M3/M4 run downward; w_nxt_down is the direction of the following element
  assign w_down     = (r_elem == 3'd3) || (r_elem == 3'd4);
  assign w_nxt_down = (r_elem == 3'd2) || (r_elem == 3'd3);
  assign w_last     = w_down ? (r_addr == '0) : (r_addr == '1);
  assign w_step     = w_down ? (r_addr - A_ONE) : (r_addr + A_ONE);

  assign w_wval = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? ~BG : BG;
  assign w_rexp = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? ~BG : BG;

  assign w_miss   = (r_state == S_CMP) && (mem_rdata != w_rexp);
  assign w_launch = (r_state == S_IDLE) && start && !abort;
  assign w_kill   = (r_state != S_IDLE) && abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_elem  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_elem  <= w_nxt_elem;
      r_addr  <= w_nxt_addr;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_elem  = r_elem;
    w_nxt_addr  = r_addr;
    unique case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_nxt_state = S_WR;
          w_nxt_elem  = '0;
          w_nxt_addr  = '0;
        end
      end
      S_WR: begin
        if ((r_elem == 3'd0) && !w_last) begin
          w_nxt_state = S_WR;
        end else begin
          w_nxt_state = S_RD;
        end
        if (w_last) begin
          w_nxt_elem = r_elem + 3'd1;
          w_nxt_addr = w_nxt_down ? '1 : '0;
        end else begin
          w_nxt_addr = w_step;
        end
      end
      S_RD: begin
        w_nxt_state = S_CMP;
      end
      S_CMP: begin
        if (r_elem != 3'd5) begin
          w_nxt_state = S_WR;
        end else if (w_last) begin
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_state = S_RD;
          w_nxt_addr  = w_step;
        end
`ifdef MARCH_STOP_ON_FAIL_EN
        if (w_miss) begin
          w_nxt_state = S_DONE;
        end
`else
`endif
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
    if (w_kill) begin
      w_nxt_state = S_IDLE;
      w_nxt_elem  = '0;
      w_nxt_addr  = '0;
    end
  end

  // abort outranks a same-cycle miscompare and the DONE verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_count <= '0;
      r_fail_addr  <= '0;
      r_fail_exp   <= '0;
      r_fail_act   <= '0;
      r_pass       <= 1'b0;
    end else if (w_launch) begin
      r_fail_count <= '0;
      r_fail_addr  <= '0;
      r_fail_exp   <= '0;
      r_fail_act   <= '0;
      r_pass       <= 1'b0;
    end else if (w_kill) begin
      r_pass <= 1'b0;
    end else if (w_miss) begin
      if (r_fail_count == 8'd0) begin
        r_fail_addr <= r_addr;
        r_fail_exp  <= w_rexp;
        r_fail_act  <= mem_rdata;
      end
      if (r_fail_count != 8'hFF) begin
        r_fail_count <= r_fail_count + 8'd1;
      end
    end else if (r_state == S_DONE) begin
      r_pass <= (r_fail_count == 8'd0);
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE) && !abort;
  assign pass       = r_pass;
  assign mem_cs     = (r_state == S_WR) || (r_state == S_RD) ||
                      (r_state == S_CMP);
  assign mem_rwbar  = (r_state != S_WR);
  assign mem_addr   = mem_cs ? r_addr : '0;
  assign mem_wdata  = (r_state == S_WR) ? w_wval : '0;
  assign fail_count = r_fail_count;
  assign fail_addr  = r_fail_addr;
  assign fail_exp   = r_fail_exp;
  assign fail_act   = r_fail_act;

endmodule
